grid_walker_seq: RTL and testbench
==================================

Name: grid_walker_seq

Overview:
- Sequential, parametrised successor to the combinational grid-walk adder.
- Accepts move commands (direction, distance) over a valid/ready handshake and steps a 2-D position (X, Y) one unit per clock.
- Handles grid-edge conditions and tracks completed moves.
- Sits between the command source (switch/FSM front end) and the position display/checker logic.

Parameters:
- COORD_W, 4: width of each coordinate; grid spans 0 to 2^COORD_W-1.
- DIS_W, 2: width of the distance field per command.
- MCNT_W, 8: width of the completed-move counter.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- load_valid  input  1  request to load the start position (honoured only in IDLE).
- init_x  input  COORD_W  start X.
- init_y  input  COORD_W  start Y.
- cmd_valid  input  1  move command present.
- cmd_dir  input  2  00 = +X, 01 = -X, 10 = +Y, 11 = -Y.
- cmd_dis  input  DIS_W  unit steps to move.
- cmd_ready  output  1  block can accept a command (high in IDLE only).
- pos_x  output  COORD_W  current X.
- pos_y  output  COORD_W  current Y.
- busy  output  1  high in STEP.
- move_done  output  1  one-cycle pulse per completed command.
- edge_hit  output  1  sticky flag: a step hit the grid boundary.
- move_count  output  MCNT_W  completed commands, saturating.

Behaviour:
- Reset (asynchronous, any state, including mid-STEP):
  - pos_x = 0, pos_y = 0, state = IDLE, busy = 0, move_done = 0, edge_hit = 0, move_count = 0, internal remaining-step counter = 0.
  - cmd_ready = 1 once reset is released.
- States: IDLE, STEP.
- cmd_ready = (state == IDLE), combinational from state. busy = (state == STEP). All other outputs are registered.
- IDLE, load_valid = 1 (takes priority over cmd_valid):
  - pos <= init, edge_hit <= 0, move_count <= 0.
  - Any simultaneous command is not accepted.
- IDLE, cmd_valid = 1 and no load: command accepted on edge T; dir and dis are latched.
  - dis = 0: stay in IDLE, no position change, move_done = 1 in the cycle after T, move_count increments.
  - dis = d > 0: go to STEP with remaining = d.
- STEP: one unit step per edge, on edges T+1 .. T+d. remaining decrements each edge.
  - On the edge where remaining goes 1 -> 0: return to IDLE and register move_done = 1 for exactly one cycle (the cycle after T+d).
  - move_count increments on that same edge.
  - cmd_ready is high in that same cycle, so a back-to-back command can be accepted on edge T+d+1 with no bubble.
- load_valid and cmd_valid are ignored while in STEP.
- Boundary, default (saturate):
  - A step that would go below 0 or above 2^COORD_W-1 leaves the coordinate unchanged and sets edge_hit.
  - The remaining steps are still consumed one per cycle, so latency stays exactly d.
- edge_hit stays set until reset or load.
- move_count saturates at 2^MCNT_W-1; it does not wrap.
- Only the coordinate selected by dir changes; the other holds.

Optional Feature:
- Macro: GRID_WRAP_EN.
- Defined: boundary steps wrap modulo 2^COORD_W (0 - 1 -> max, max + 1 -> 0), and edge_hit is set on every wrap.
- Undefined: saturate behaviour as above.
- Latency, handshake and counters are identical in both builds.

Test Plan:
- Load at (3,5), then +X dis = 3 -> pos_x 4, 5, 6 on three successive edges; pos_y = 5 throughout; move_done pulses once, in the cycle after pos_x reaches 6; move_count = 1; edge_hit = 0.
- From y = 1, -Y dis = 3 -> saturate build: y = 0, 0, 0 with edge_hit = 1 and 3-cycle latency. GRID_WRAP_EN build: y = 0, 15, 14 with edge_hit = 1.
- dis = 0, +Y -> move_done high in the cycle after acceptance; position unchanged; move_count +1; cmd_ready never drops.
- cmd_valid held high with +X dis = 2 followed by -X dis = 1 -> second command accepted in the move_done cycle; final pos_x equals start + 1; exactly two move_done pulses, 4 cycles apart from the first acceptance.
- load_valid pulsed during STEP -> ignored, position unaffected. Reset asserted mid-STEP -> all outputs reach reset values immediately without a clock edge; cmd_ready = 1 after release.
- MCNT_W = 2, five completed commands -> move_count holds at 3. A subsequent load -> move_count = 0 and edge_hit = 0.

Source files
------------

// File: rtl/grid_walker_seq.sv
// Grid walker: steps (X, Y) one unit per clock from valid/ready move commands.
// Define GRID_WRAP_EN to wrap at grid edges instead of saturating.
module grid_walker_seq #(
  parameter int COORD_W = 4,
  parameter int DIS_W   = 2,
  parameter int MCNT_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  input  logic [COORD_W-1:0] init_x,
  input  logic [COORD_W-1:0] init_y,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_dir,
  input  logic [DIS_W-1:0]   cmd_dis,
  output logic               cmd_ready,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               busy,
  output logic               move_done,
  output logic               edge_hit,
  output logic [MCNT_W-1:0]  move_count
);

`ifdef GRID_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [COORD_W-1:0] CMAX = '1;
  localparam logic [COORD_W-1:0] CMIN = '0;
  localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);

  typedef enum logic {
    IDLE,
    STEP
  } state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d;
  logic [COORD_W-1:0] pos_y_q, pos_y_d;
  logic [1:0]         dir_q, dir_d;
  logic [DIS_W-1:0]   rem_q, rem_d;
  logic               done_q, done_d;
  logic               edge_q, edge_d;
  logic [MCNT_W-1:0]  cnt_q, cnt_d;

  logic [COORD_W-1:0] step_x;
  logic [COORD_W-1:0] step_y;
  logic               step_hit;
  logic [MCNT_W-1:0]  cnt_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pos_x_q <= '0;
      pos_y_q <= '0;
      dir_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      edge_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      edge_q  <= edge_d;
      cnt_q   <= cnt_d;
    end
  end

  // Candidate position for one unit step along the latched direction.
  always_comb begin
    step_x   = pos_x_q;
    step_y   = pos_y_q;
    step_hit = 1'b0;
    unique case (dir_q)
      2'b00: begin
        step_hit = (pos_x_q == CMAX);
        step_x   = pos_x_q + ONE;
      end
      2'b01: begin
        step_hit = (pos_x_q == CMIN);
        step_x   = pos_x_q - ONE;
      end
      2'b10: begin
        step_hit = (pos_y_q == CMAX);
        step_y   = pos_y_q + ONE;
      end
      2'b11: begin
        step_hit = (pos_y_q == CMIN);
        step_y   = pos_y_q - ONE;
      end
    endcase
    if (step_hit && !WRAP) begin
      step_x = pos_x_q;
      step_y = pos_y_q;
    end
  end

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + MCNT_W'(1);

  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    edge_d  = edge_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          pos_x_d = init_x;
          pos_y_d = init_y;
          edge_d  = 1'b0;
          cnt_d   = '0;
        end else if (cmd_valid) begin
          dir_d = cmd_dir;
          if (cmd_dis == '0) begin
            done_d = 1'b1;
            cnt_d  = cnt_inc;
          end else begin
            rem_d   = cmd_dis;
            state_d = STEP;
          end
        end
      end
      STEP: begin
        pos_x_d = step_x;
        pos_y_d = step_y;
        rem_d   = rem_q - DIS_W'(1);
        if (step_hit) edge_d = 1'b1;
        // Last step: done is registered so it pulses while cmd_ready is high.
        if (rem_q == DIS_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q == STEP);
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign move_done  = done_q;
  assign edge_hit   = edge_q;
  assign move_count = cnt_q;

endmodule

// File: tb/tb_grid_walker_seq.sv
// Directed vector bench for grid_walker_seq (saturate or GRID_WRAP_EN build).
module tb_grid_walker_seq;

`ifdef GRID_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic [3:0] init_x, init_y;
  logic       cmd_valid;
  logic [1:0] cmd_dir;
  logic [1:0] cmd_dis;
  logic       cmd_ready, busy, move_done, edge_hit;
  logic [3:0] pos_x, pos_y;
  logic [7:0] move_count;
  logic       rdy2, busy2, done2, edge2;
  logic [3:0] px2, py2;
  logic [1:0] cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  grid_walker_seq u_dut (
    .clk(clk), .reset(reset), .load_valid(load_valid),
    .init_x(init_x), .init_y(init_y), .cmd_valid(cmd_valid),
    .cmd_dir(cmd_dir), .cmd_dis(cmd_dis), .cmd_ready(cmd_ready),
    .pos_x(pos_x), .pos_y(pos_y), .busy(busy),
    .move_done(move_done), .edge_hit(edge_hit), .move_count(move_count)
  );

  grid_walker_seq #(.MCNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .load_valid(load_valid),
    .init_x(init_x), .init_y(init_y), .cmd_valid(cmd_valid),
    .cmd_dir(cmd_dir), .cmd_dis(cmd_dis), .cmd_ready(rdy2),
    .pos_x(px2), .pos_y(py2), .busy(busy2),
    .move_done(done2), .edge_hit(edge2), .move_count(cnt2)
  );

  typedef struct {
    logic       ld;
    logic [3:0] ix, iy;
    logic       cv;
    logic [1:0] dir, dis;
    logic [3:0] px, py;
    logic       rdy, bsy, dn, eh;
    logic [7:0] cnt;
    logic [1:0] c2;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic ld, input logic [3:0] ix, iy,
                     input logic cv, input logic [1:0] dir, dis,
                     input logic [3:0] px, py,
                     input logic rdy, bsy, dn, eh,
                     input logic [7:0] cnt, input logic [1:0] c2);
    vec_t v;
    v.ld = ld; v.ix = ix; v.iy = iy; v.cv = cv; v.dir = dir; v.dis = dis;
    v.px = px; v.py = py; v.rdy = rdy; v.bsy = bsy; v.dn = dn; v.eh = eh;
    v.cnt = cnt; v.c2 = c2;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic idle_in();
    load_valid = 1'b0; init_x = '0; init_y = '0;
    cmd_valid = 1'b0; cmd_dir = '0; cmd_dis = '0;
  endtask

  logic [3:0] y10, y11, x26, x27;

  initial begin
    y10 = WRAP ? 4'd15 : 4'd0;
    y11 = WRAP ? 4'd14 : 4'd0;
    x26 = WRAP ? 4'd0  : 4'd15;
    x27 = WRAP ? 4'd1  : 4'd15;
    //   ld ix  iy  cv dir  dis    px  py  rd bs dn eh cnt c2
    add(1, 3, 5, 0, 2'd0, 2'd0,  3,  5, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 2'd0, 2'd3,  3,  5, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 2'd0, 2'd0,  4,  5, 0, 1, 0, 0, 0, 0);
    add(1, 9, 9, 0, 2'd0, 2'd0,  5,  5, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 2'd0, 2'd0,  6,  5, 1, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 2'd0, 2'd0,  6,  5, 1, 0, 0, 0, 1, 1);
    add(1, 2, 1, 0, 2'd0, 2'd0,  2,  1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 2'd3, 2'd3,  2,  1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 2'd0, 2'd0,  2,  0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 2'd0, 2'd0,  2, y10, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 2'd0, 2'd0,  2, y11, 1, 0, 1, 1, 1, 1);
    add(0, 0, 0, 0, 2'd0, 2'd0,  2, y11, 1, 0, 0, 1, 1, 1);
    add(0, 0, 0, 1, 2'd2, 2'd0,  2, y11, 1, 0, 1, 1, 2, 2);
    add(0, 0, 0, 0, 2'd0, 2'd0,  2, y11, 1, 0, 0, 1, 2, 2);
    add(0, 0, 0, 1, 2'd0, 2'd2,  2, y11, 0, 1, 0, 1, 2, 2);
    add(0, 0, 0, 1, 2'd0, 2'd2,  3, y11, 0, 1, 0, 1, 2, 2);
    add(0, 0, 0, 1, 2'd0, 2'd2,  4, y11, 1, 0, 1, 1, 3, 3);
    add(0, 0, 0, 1, 2'd1, 2'd1,  4, y11, 0, 1, 0, 1, 3, 3);
    add(0, 0, 0, 0, 2'd0, 2'd0,  3, y11, 1, 0, 1, 1, 4, 3);
    add(0, 0, 0, 0, 2'd0, 2'd0,  3, y11, 1, 0, 0, 1, 4, 3);
    add(0, 0, 0, 1, 2'd2, 2'd0,  3, y11, 1, 0, 1, 1, 5, 3);
    add(1, 0, 0, 1, 2'd0, 2'd1,  0,  0, 1, 0, 0, 0, 0, 0);
    add(1, 14, 7, 0, 2'd0, 2'd0, 14,  7, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 2'd0, 2'd3, 14,  7, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 2'd0, 2'd0, 15,  7, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 2'd0, 2'd0, x26, 7, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 2'd0, 2'd0, x27, 7, 1, 0, 1, 1, 1, 1);

    idle_in();
    reset = 1'b1;
    #1;
    chk("rst_px", 0, pos_x, 0);
    chk("rst_py", 0, pos_y, 0);
    chk("rst_busy", 0, busy, 0);
    chk("rst_done", 0, move_done, 0);
    chk("rst_edge", 0, edge_hit, 0);
    chk("rst_cnt", 0, move_count, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rdy", 0, cmd_ready, 1);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      load_valid = vq[i].ld; init_x = vq[i].ix; init_y = vq[i].iy;
      cmd_valid = vq[i].cv; cmd_dir = vq[i].dir; cmd_dis = vq[i].dis;
      @(posedge clk);
      #1;
      chk("pos_x", i, pos_x, vq[i].px);
      chk("pos_y", i, pos_y, vq[i].py);
      chk("cmd_ready", i, cmd_ready, vq[i].rdy);
      chk("busy", i, busy, vq[i].bsy);
      chk("move_done", i, move_done, vq[i].dn);
      chk("edge_hit", i, edge_hit, vq[i].eh);
      chk("move_count", i, move_count, vq[i].cnt);
      chk("count_sat2", i, cnt2, vq[i].c2);
    end

    // Reset mid-STEP: everything clears without a clock edge.
    @(negedge clk);
    idle_in();
    cmd_valid = 1'b1; cmd_dir = 2'd2; cmd_dis = 2'd3;
    @(negedge clk);
    idle_in();
    @(posedge clk);
    #1;
    chk("mid_busy", 0, busy, 1);
    chk("mid_py", 0, pos_y, 8);
    #3;
    reset = 1'b1;
    #1;
    chk("async_px", 0, pos_x, 0);
    chk("async_py", 0, pos_y, 0);
    chk("async_busy", 0, busy, 0);
    chk("async_done", 0, move_done, 0);
    chk("async_edge", 0, edge_hit, 0);
    chk("async_cnt", 0, move_count, 0);
    chk("async_cnt2", 0, cnt2, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rdy", 0, cmd_ready, 1);
    chk("post_busy", 0, busy, 0);
    chk("post_py", 0, pos_y, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
